// File: rtl/mem_access_stage.sv
// Memory-access stage: turns execute-stage LDR/STR/LDRB/STRB into a req/ack RAM
// transaction, stalls execute while the RAM is busy and returns formatted load data.
module mem_access_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic        ex_byte,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_str_data,
    input  logic [3:0]  ex_rd,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ram_data2,
    output logic        forward_w_data,
    output logic [3:0]  wb_addr,
    output logic        wb_en
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t      state;
    logic        lat_load;
    logic        lat_byte;
    logic [1:0]  lat_off;
    logic [3:0]  lat_rd;

    logic        accept;
    logic [3:0]  acc_be;
    logic [31:0] acc_wdata;
    logic [31:0] load_fmt;

    always_comb begin
        accept    = ex_valid & (ex_load | ex_store);
        acc_be    = ex_byte ? (4'b0001 << ex_addr[1:0]) : 4'hF;
        acc_wdata = ex_byte ? {4{ex_str_data[7:0]}} : ex_str_data;
        stall     = (state == WAIT);
    end

    // Rotate right by whole bytes; the low byte of the rotated word is the addressed lane.
    always_comb begin
        load_fmt = mem_rdata;
        case (lat_off)
            2'd0: load_fmt = mem_rdata;
            2'd1: load_fmt = {mem_rdata[7:0],  mem_rdata[31:8]};
            2'd2: load_fmt = {mem_rdata[15:0], mem_rdata[31:16]};
            2'd3: load_fmt = {mem_rdata[23:0], mem_rdata[31:24]};
            default: load_fmt = mem_rdata;
        endcase
        if (lat_byte) begin
            load_fmt = {24'd0, load_fmt[7:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            lat_load       <= 1'b0;
            lat_byte       <= 1'b0;
            lat_off        <= '0;
            lat_rd         <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_be         <= '0;
            ram_data2      <= '0;
            forward_w_data <= 1'b0;
            wb_addr        <= '0;
            wb_en          <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    wb_en          <= 1'b0;
                    forward_w_data <= 1'b0;
                    if (accept) begin
                        state     <= WAIT;
                        mem_req   <= 1'b1;
                        mem_we    <= ~ex_load;
                        mem_addr  <= {ex_addr[31:2], 2'b00};
                        mem_wdata <= acc_wdata;
                        mem_be    <= acc_be;
                        lat_load  <= ex_load;
                        lat_byte  <= ex_byte;
                        lat_off   <= ex_addr[1:0];
                        lat_rd    <= ex_rd;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        if (lat_load) begin
                            ram_data2      <= load_fmt;
                            wb_en          <= 1'b1;
                            forward_w_data <= 1'b1;
                            wb_addr        <= lat_rd;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
